// File: rtl/map_row_cache_pkg.sv
// Map geometry shared by map_row_cache and map_overlay, plus the raster-line to map-row helper.
// Everything derives from the three log2 parameters below.
package map_row_cache_pkg;

    localparam int H_VIEW    = 640;
    localparam int V_TOTAL   = 525;
    localparam int MAP_WBITS = 4;
    localparam int MAP_HBITS = 4;
    localparam int MAP_SCALE = 3;

    localparam int MAP_WIDTH          = 1 << MAP_WBITS;
    localparam int MAP_HEIGHT         = 1 << MAP_HBITS;
    // One extra line covers the closing gridline under the last row.
    localparam int MAP_OVERLAY_HEIGHT = (MAP_HEIGHT << MAP_SCALE) + 1;

    typedef logic [MAP_WBITS-1:0] map_col_t;
    typedef logic [MAP_HBITS-1:0] map_row_t;
    typedef logic [1:0]           cell_t;

    // Truncates: the gridline line below the map maps back to row 0.
    function automatic map_row_t row_of_line(input logic [9:0] line);
        return line[MAP_SCALE+MAP_HBITS-1:MAP_SCALE];
    endfunction

endpackage

// File: rtl/map_row_cache_if.sv
// ROM-port and overlay-read signals of the map row cache.
// master = cache side, slave = arbiter/ROM/overlay side.
interface map_row_cache_if;
    import map_row_cache_pkg::*;

    logic     rom_req;
    logic     rom_gnt;
    map_col_t o_rom_col;
    map_row_t o_rom_row;
    cell_t    i_rom_val;
    map_col_t ov_col;
    cell_t    ov_val;
    logic     row_valid;
    logic     fetch_miss;

    modport master (
        output rom_req, o_rom_col, o_rom_row, ov_val, row_valid, fetch_miss,
        input  rom_gnt, i_rom_val, ov_col
    );

    modport slave (
        input  rom_req, o_rom_col, o_rom_row, ov_val, row_valid, fetch_miss,
        output rom_gnt, i_rom_val, ov_col
    );

endinterface

// File: rtl/map_row_cache_row_buffer.sv
// MAP_WIDTH x 2-bit register file: one synchronous write port, one async read port.
// Synchronous clear has priority over the write.
module map_row_buffer
    import map_row_cache_pkg::*;
(
    input  logic     clk,
    input  logic     clr,
    input  logic     we,
    input  map_col_t waddr,
    input  cell_t    wdat,
    input  map_col_t raddr,
    output cell_t    rdat
);

    cell_t mem [MAP_WIDTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MAP_WIDTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/map_row_cache.sv
// Prefetches the next line's map row from the shared ROM during hblank; serves it combinationally.
// Fetch starts at hpos==H_VIEW, one ROM cell per granted cycle, aborted if the line starts first.
module map_row_cache
    import map_row_cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    map_row_cache_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        FETCH    = 2'd2
    } state_t;

    state_t   state;
    logic     rom_req;
    map_col_t rom_col;
    map_row_t rom_row;
    map_row_t cached_row;
    logic     row_valid;
    logic     fetch_miss;

    logic [9:0] next_line;
    map_row_t   next_row;
    logic       in_overlay;
    logic       trigger;
    logic       abort;
    logic       capture;
    cell_t      buf_rdat;

    assign next_line  = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    assign next_row   = row_of_line(next_line);
    assign in_overlay = next_line < 10'(MAP_OVERLAY_HEIGHT);
    // Eight raster lines share a map row, so only the first of them actually fetches.
    assign trigger    = (state == IDLE) && (hpos == 10'(H_VIEW)) && in_overlay
                        && !(row_valid && cached_row == next_row);
    assign abort      = (state != IDLE) && (hpos == 10'd0);
    assign capture    = (state == FETCH) && bus.rom_gnt && !abort;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rom_req    <= 1'b0;
            rom_col    <= '0;
            rom_row    <= '0;
            cached_row <= '0;
            row_valid  <= 1'b0;
            fetch_miss <= 1'b0;
        end else begin
            fetch_miss <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state     <= WAIT_GNT;
                        rom_req   <= 1'b1;
                        rom_row   <= next_row;
                        rom_col   <= '0;
                        row_valid <= 1'b0;
                    end
                end
                WAIT_GNT: begin
                    if (abort) begin
                        state      <= IDLE;
                        rom_req    <= 1'b0;
                        fetch_miss <= 1'b1;
                    end else if (bus.rom_gnt) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Abort wins even over the final capture: a late row is no use to this line.
                    if (abort) begin
                        state      <= IDLE;
                        rom_req    <= 1'b0;
                        fetch_miss <= 1'b1;
                    end else if (capture) begin
                        rom_col <= rom_col + map_col_t'(1);
                        if (rom_col == map_col_t'(MAP_WIDTH - 1)) begin
                            state      <= IDLE;
                            rom_req    <= 1'b0;
                            row_valid  <= 1'b1;
                            cached_row <= rom_row;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rom_req <= 1'b0;
                end
            endcase
        end
    end

    map_row_buffer u_row_buffer (
        .clk   (clk),
        .clr   (!reset_n),
        .we    (capture),
        .waddr (rom_col),
        .wdat  (bus.i_rom_val),
        .raddr (bus.ov_col),
        .rdat  (buf_rdat)
    );

    assign bus.rom_req    = rom_req;
    assign bus.o_rom_col  = rom_col;
    assign bus.o_rom_row  = rom_row;
    assign bus.row_valid  = row_valid;
    assign bus.fetch_miss = fetch_miss;
    assign bus.ov_val     = row_valid ? buf_rdat : 2'b00;

endmodule
